// File: rtl/nand_cpu_pkg.sv
// Shared types for the nand_cpu core: data word, register address,
// and the packet carried on the regfile write port.
package nand_cpu_pkg;

  localparam int NREGS  = 16;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [15:0]       word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      use_rw;
    reg_addr_t rw_addr;
    word_t     data;
    logic      write_ps;
    logic      ps;
  } wb_pkt_t;

  localparam wb_pkt_t WB_PKT_RESET = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0};

  // One-hot decode of a register address onto the busy vector.
  function automatic logic [NREGS-1:0] reg_onehot(input reg_addr_t addr);
    logic [NREGS-1:0] one;
    one = {{(NREGS-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// In-order queue of destination registers for loads still outstanding
// at d_mem. Also publishes which registers have a pending load.
module wb_pending_fifo
  import nand_cpu_pkg::*;
#(
  parameter int LD_DEPTH = 4
)
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  logic [REG_AW-1:0] push_addr,
  input  logic              pop,
  output logic [REG_AW-1:0] head_addr,
  output logic              full,
  output logic              empty,
  output logic [NREGS-1:0]  busy
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = $clog2(LD_DEPTH + 1);

  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic [REG_AW-1:0]  addr_mem [LD_DEPTH];
  logic [LD_DEPTH-1:0] entry_valid;
  logic               push_ok;
  logic               pop_ok;

  // Full blocks new issues outright; a pop in the same cycle does not make room.
  assign full      = (count == CW'(LD_DEPTH));
  assign empty     = (count == {CW{1'b0}});
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_addr = addr_mem[rd_ptr];

  // Queue storage, pointers (wrap naturally, depth is a power of 2) and occupancy.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_ptr      <= {PW{1'b0}};
      wr_ptr      <= {PW{1'b0}};
      count       <= {CW{1'b0}};
      entry_valid <= {LD_DEPTH{1'b0}};
      for (int i = 0; i < LD_DEPTH; i++) begin
        addr_mem[i] <= {REG_AW{1'b0}};
      end
    end else begin
      if (pop_ok) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + PW'(1);
      end
      if (push_ok) begin
        addr_mem[wr_ptr]    <= push_addr;
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A register is busy while any live entry targets it, so duplicates keep it busy.
  always_comb begin
    busy = {NREGS{1'b0}};
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (entry_valid[i]) begin
        busy = busy | reg_onehot(addr_mem[i]);
      end else begin
        busy = busy;
      end
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Producer side of the regfile write port. Load returns and ALU results
// share one registered write port; load returns win and the ALU is held.
module writeback_unit
  import nand_cpu_pkg::*;
#(
  parameter int LD_DEPTH = 4
)
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic              alu_use_rw,
  input  logic [REG_AW-1:0] alu_rw_addr,
  input  logic [15:0]       alu_data,
  input  logic              alu_write_ps,
  input  logic              alu_ps,
  input  logic              ld_issue_valid,
  output logic              ld_issue_ready,
  input  logic [REG_AW-1:0] ld_rw_addr,
  input  logic              mem_resp_valid,
  input  logic [15:0]       mem_resp_data,
  output logic [NREGS-1:0]  busy,
  output logic              err,
  output logic              wb_valid,
  output logic              wb_use_rw,
  output logic [REG_AW-1:0] wb_rw_addr,
  output logic [15:0]       wb_data,
  output logic              wb_write_ps,
  output logic              wb_ps
);

  logic              q_full;
  logic              q_empty;
  logic [REG_AW-1:0] head_addr;
  logic              take_mem;
  logic              stray_resp;
  logic              wb_valid_reg;
  wb_pkt_t           wb_pkt;
  logic              next_valid;
  wb_pkt_t           next_pkt;

  // A response only counts when there is a load waiting for it.
  assign take_mem       = mem_resp_valid & ~q_empty;
  assign stray_resp     = mem_resp_valid & q_empty;
  assign alu_ready      = ~take_mem;
  assign ld_issue_ready = ~q_full;

  wb_pending_fifo #(
    .LD_DEPTH (LD_DEPTH)
  ) u_pending (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (ld_issue_valid),
    .push_addr (ld_rw_addr),
    .pop       (take_mem),
    .head_addr (head_addr),
    .full      (q_full),
    .empty     (q_empty),
    .busy      (busy)
  );

  // Pick next cycle's write: load return first, else ALU, else idle with fields held.
  always_comb begin
    next_valid = 1'b0;
    next_pkt   = wb_pkt;
    if (take_mem) begin
      next_valid = 1'b1;
      next_pkt   = '{use_rw: 1'b1, rw_addr: head_addr, data: mem_resp_data,
                     write_ps: 1'b0, ps: 1'b0};
    end else if (alu_valid) begin
      next_valid = 1'b1;
      next_pkt   = '{use_rw: alu_use_rw, rw_addr: alu_rw_addr, data: alu_data,
                     write_ps: alu_write_ps, ps: alu_ps};
    end else begin
      next_valid = 1'b0;
      next_pkt   = wb_pkt;
    end
  end

  // Registered write port and the sticky empty-queue response flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wb_valid_reg <= 1'b0;
      wb_pkt       <= WB_PKT_RESET;
      err          <= 1'b0;
    end else begin
      wb_valid_reg <= next_valid;
      wb_pkt       <= next_pkt;
      err          <= err | stray_resp;
    end
  end

  assign wb_valid    = wb_valid_reg;
  assign wb_use_rw   = wb_pkt.use_rw;
  assign wb_rw_addr  = wb_pkt.rw_addr;
  assign wb_data     = wb_pkt.data;
  assign wb_write_ps = wb_pkt.write_ps;
  assign wb_ps       = wb_pkt.ps;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: a directed vector table, hand
// sequences for queue-full / error / reset, and a randomized phase checked
// against a queue-based reference model.
module tb_writeback_unit;

  localparam int LD = 4;

  logic        clk;
  logic        n_rst;
  logic        alu_valid, alu_ready, alu_use_rw, alu_write_ps, alu_ps;
  logic [3:0]  alu_rw_addr;
  logic [15:0] alu_data;
  logic        ld_issue_valid, ld_issue_ready;
  logic [3:0]  ld_rw_addr;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
  logic [15:0] busy;
  logic        err;
  logic        wb_valid, wb_use_rw, wb_write_ps, wb_ps;
  logic [3:0]  wb_rw_addr;
  logic [15:0] wb_data;

  writeback_unit #(.LD_DEPTH(LD)) dut (
    .clk(clk), .n_rst(n_rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_use_rw(alu_use_rw),
    .alu_rw_addr(alu_rw_addr), .alu_data(alu_data), .alu_write_ps(alu_write_ps),
    .alu_ps(alu_ps), .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
    .ld_rw_addr(ld_rw_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .err(err), .wb_valid(wb_valid), .wb_use_rw(wb_use_rw),
    .wb_rw_addr(wb_rw_addr), .wb_data(wb_data), .wb_write_ps(wb_write_ps), .wb_ps(wb_ps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic av; logic ause; logic [3:0] aaddr; logic [15:0] adata; logic awps; logic aps;
    logic li; logic [3:0] laddr; logic mr; logic [15:0] mdata;
  } stim_t;

  typedef struct {
    stim_t s;
    logic rdy; logic v; logic use_rw; logic [3:0] addr; logic [15:0] data;
    logic wps; logic ps; logic [15:0] bsy;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Reference model: outstanding loads in issue order plus the expected port.
  logic [3:0]  pend[$];
  logic        m_valid, m_use, m_wps, m_ps, m_err;
  logic [3:0]  m_addr;
  logic [15:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    b = 16'h0000;
    foreach (pend[i]) b[pend[i]] = 1'b1;
    return b;
  endfunction

  function automatic bit in_pend(input logic [3:0] a);
    foreach (pend[i]) if (pend[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000};
    return s;
  endfunction

  function automatic stim_t alu(input logic u, input logic [3:0] a, input logic [15:0] d,
                                input logic w, input logic p);
    stim_t s;
    s = idle();
    s.av = 1'b1; s.ause = u; s.aaddr = a; s.adata = d; s.awps = w; s.aps = p;
    return s;
  endfunction

  function automatic stim_t ld(input logic [3:0] a);
    stim_t s;
    s = idle();
    s.li = 1'b1; s.laddr = a;
    return s;
  endfunction

  function automatic stim_t resp(input logic [15:0] d);
    stim_t s;
    s = idle();
    s.mr = 1'b1; s.mdata = d;
    return s;
  endfunction

  // Called at posedge+1: drive, check combinational outputs, advance model, check registers.
  task automatic step(input stim_t s, output logic rdy_seen);
    int had;
    logic [3:0] a;
    alu_valid = s.av; alu_use_rw = s.ause; alu_rw_addr = s.aaddr; alu_data = s.adata;
    alu_write_ps = s.awps; alu_ps = s.aps;
    ld_issue_valid = s.li; ld_rw_addr = s.laddr;
    mem_resp_valid = s.mr; mem_resp_data = s.mdata;
    #1;
    had = pend.size();
    rdy_seen = alu_ready;
    chk("alu_ready", 32'(alu_ready), 32'(!(s.mr && had > 0)));
    chk("ld_issue_ready", 32'(ld_issue_ready), 32'(had < LD));
    chk("busy", 32'(busy), 32'(model_busy()));
    if (s.mr && had > 0) begin
      a = pend.pop_front();
      m_valid = 1'b1; m_use = 1'b1; m_addr = a; m_data = s.mdata; m_wps = 1'b0; m_ps = 1'b0;
    end else if (s.av) begin
      m_valid = 1'b1; m_use = s.ause; m_addr = s.aaddr; m_data = s.adata;
      m_wps = s.awps; m_ps = s.aps;
    end else begin
      m_valid = 1'b0;
    end
    if (s.mr && had == 0) m_err = 1'b1;
    if (s.li && had < LD) pend.push_back(s.laddr);
    @(posedge clk); #1;
    chk("wb_valid", 32'(wb_valid), 32'(m_valid));
    chk("wb_use_rw", 32'(wb_use_rw), 32'(m_use));
    chk("wb_rw_addr", 32'(wb_rw_addr), 32'(m_addr));
    chk("wb_data", 32'(wb_data), 32'(m_data));
    chk("wb_write_ps", 32'(wb_write_ps), 32'(m_wps));
    chk("wb_ps", 32'(wb_ps), 32'(m_ps));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Synchronous reset for one edge with idle inputs, then explicit reset-state checks.
  task automatic do_reset();
    n_rst = 1'b0;
    alu_valid = 1'b0; alu_use_rw = 1'b0; alu_rw_addr = 4'h0; alu_data = 16'h0000;
    alu_write_ps = 1'b0; alu_ps = 1'b0; ld_issue_valid = 1'b0; ld_rw_addr = 4'h0;
    mem_resp_valid = 1'b0; mem_resp_data = 16'h0000;
    @(posedge clk); #1;
    n_rst = 1'b1;
    pend.delete();
    m_valid = 1'b0; m_use = 1'b0; m_addr = 4'h0; m_data = 16'h0000;
    m_wps = 1'b0; m_ps = 1'b0; m_err = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_wb_fields", {11'h0, wb_use_rw, wb_rw_addr, wb_data[14:0], wb_write_ps}, 32'h0);
    chk("rst_wb_data_ps", {15'h0, wb_data, wb_ps}, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_alu_ready", 32'(alu_ready), 32'h1);
    chk("rst_ld_issue_ready", 32'(ld_issue_ready), 32'h1);
    @(posedge clk); #1;
  endtask

  vec_t tbl[12];
  logic rdy;
  stim_t s;
  logic [31:0] r;

  initial begin
    n_rst = 1'b0;
    alu_valid = 1'b0; alu_use_rw = 1'b0; alu_rw_addr = 4'h0; alu_data = 16'h0000;
    alu_write_ps = 1'b0; alu_ps = 1'b0; ld_issue_valid = 1'b0; ld_rw_addr = 4'h0;
    mem_resp_valid = 1'b0; mem_resp_data = 16'h0000;

    // Directed vectors from reset: ALU write, load round-trip, collision, no-effect ALU.
    tbl[0]  = '{alu(1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b1), 1'b1, 1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b1, 16'h0000};
    tbl[1]  = '{idle(),                                  1'b1, 1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b1, 16'h0000};
    tbl[2]  = '{ld(4'd5),                                1'b1, 1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b1, 16'h0020};
    tbl[3]  = '{idle(),                                  1'b1, 1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b1, 16'h0020};
    tbl[4]  = '{idle(),                                  1'b1, 1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b1, 16'h0020};
    tbl[5]  = '{resp(16'h1234),                          1'b0, 1'b1, 1'b1, 4'd5, 16'h1234, 1'b0, 1'b0, 16'h0000};
    tbl[6]  = '{idle(),                                  1'b1, 1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 1'b0, 16'h0000};
    tbl[7]  = '{ld(4'd9),                                1'b1, 1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 1'b0, 16'h0200};
    tbl[8]  = '{alu(1'b1, 4'd2, 16'h5555, 1'b0, 1'b1), 1'b0, 1'b1, 1'b1, 4'd9, 16'hCAFE, 1'b0, 1'b0, 16'h0000};
    tbl[8].s.mr = 1'b1; tbl[8].s.mdata = 16'hCAFE;
    tbl[9]  = '{alu(1'b1, 4'd2, 16'h5555, 1'b0, 1'b1), 1'b1, 1'b1, 1'b1, 4'd2, 16'h5555, 1'b0, 1'b1, 16'h0000};
    tbl[10] = '{alu(1'b0, 4'd4, 16'h0001, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 4'd4, 16'h0001, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{idle(),                                  1'b1, 1'b0, 1'b0, 4'd4, 16'h0001, 1'b0, 1'b0, 16'h0000};

    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].s, rdy);
      chk($sformatf("vec%0d_alu_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_wb", i),
          {6'h0, wb_valid, wb_use_rw, wb_rw_addr, wb_data, wb_write_ps, wb_ps, 2'b00},
          {6'h0, tbl[i].v, tbl[i].use_rw, tbl[i].addr, tbl[i].data, tbl[i].wps, tbl[i].ps, 2'b00});
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
    end

    // Full queue with a duplicate destination.
    step(ld(4'd1), rdy); step(ld(4'd2), rdy); step(ld(4'd1), rdy); step(ld(4'd7), rdy);
    chk("full_ready", 32'(ld_issue_ready), 32'h0);
    chk("full_busy", 32'(busy), 32'h0086);
    step(resp(16'h0A01), rdy);
    chk("dup_busy1_held", 32'(busy), 32'h0086);
    chk("pop1_addr", 32'(wb_rw_addr), 32'h1);
    s = ld(4'd3); s.mr = 1'b1; s.mdata = 16'h0A02;
    step(s, rdy);
    chk("pushpop_busy", 32'(busy), 32'h008A);
    chk("pushpop_ready", 32'(ld_issue_ready), 32'h1);
    step(ld(4'd4), rdy);
    chk("refull_ready", 32'(ld_issue_ready), 32'h0);
    for (int i = 0; i < 4; i++) step(resp(16'h0B00 + 16'(i)), rdy);
    chk("drained_busy", 32'(busy), 32'h0);

    // Wrap-around: issue/response pairs with random gaps.
    for (int k = 0; k < 10; k++) begin
      r = $urandom;
      step(ld(r[3:0]), rdy);
      for (int g = 0; g < int'(r[5:4] % 2'd3); g++) step(idle(), rdy);
      step(resp(r[31:16]), rdy);
      chk("wrap_addr", 32'(wb_rw_addr), 32'(r[3:0]));
    end

    // Stray response, then reset with loads in flight, then a late response.
    step(resp(16'hDEAD), rdy);
    chk("stray_no_wb", 32'(wb_valid), 32'h0);
    chk("stray_err", 32'(err), 32'h1);
    step(ld(4'd6), rdy); step(ld(4'd8), rdy);
    do_reset();
    step(resp(16'hFEED), rdy);
    chk("late_resp_err", 32'(err), 32'h1);
    do_reset();

    // Randomized mixed traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      r = $urandom;
      s = idle();
      s.av = r[0]; s.aaddr = r[4:1]; s.ause = r[5] & ~in_pend(r[4:1]);
      s.awps = r[6]; s.aps = r[7]; s.adata = $urandom;
      s.li = (pend.size() < LD) && (r[9:8] != 2'b00); s.laddr = r[13:10];
      s.mr = (pend.size() > 0) ? r[14] : (r[19:15] == 5'd0);
      s.mdata = r[31:16];
      step(s, rdy);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
